// File: rtl/memory_backing_store_pkg.sv
// Shared types and constants for the word-addressed backing RAM.
// Strobe masks are also used by memory_controller when mapping op lengths.
package memory_backing_store_pkg;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_WAIT = 2'd1,
        MEM_STATE_RESP = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_RESP_ERROR_DATA = 32'h0;

    localparam logic [3:0] MEM_STROBE_BYTE = 4'b0001;
    localparam logic [3:0] MEM_STROBE_HALF = 4'b0011;
    localparam logic [3:0] MEM_STROBE_WORD = 4'b1111;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  strobe;
    } mem_req_t;

endpackage

// File: rtl/memory_backing_store_if.sv
// Memory request/response bundle between memory_controller and the RAM.
interface memory_backing_store_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [3:0]  req_strobe;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_address, req_wdata, req_strobe,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata, req_strobe,
        output req_ready, resp_valid, resp_data, resp_error
    );

endinterface

// File: rtl/memory_backing_store_byte_write_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
module memory_backing_store_byte_write_ram #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_backing_store.sv
// Backing RAM responder: one outstanding request, fixed latency,
// byte-masked writes and an out-of-range error response.
module memory_backing_store
    import memory_backing_store_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_backing_store_if.slave bus
);

    localparam bit         FAST     = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    mem_req_t    req_in, op;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic        resp_read_q, resp_read_d;
    logic        accept, enter_resp, in_range, ram_en;
    logic [31:0] ram_rdata;

    assign bus.req_ready = ~reset &&
        (state_q == MEM_STATE_IDLE || state_q == MEM_STATE_RESP);

    assign req_in = {bus.req_write, bus.req_address,
                     bus.req_wdata, bus.req_strobe};
    assign accept = bus.req_valid && bus.req_ready;

    // With single-cycle latency the RESP-entry edge is the accept edge,
    // so the RAM must see the incoming request rather than the latch.
    assign op         = (FAST && accept) ? req_in : req_q;
    assign in_range   = (op.address >> ADDR_WIDTH) == 32'd0;
    assign enter_resp = (state_q == MEM_STATE_WAIT && cnt_q == 4'd0) ||
                        (FAST && accept);
    assign ram_en     = enter_resp && in_range && ~reset;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_read_d  = 1'b0;
        if (accept) begin
            req_d = req_in;
        end
        unique case (state_q)
            MEM_STATE_IDLE, MEM_STATE_RESP: begin
                if (accept && FAST) begin
                    state_d = MEM_STATE_RESP;
                end else if (accept) begin
                    state_d = MEM_STATE_WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = MEM_STATE_IDLE;
                end
            end
            MEM_STATE_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = MEM_STATE_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MEM_STATE_IDLE;
        endcase
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_error_d = ~in_range;
            resp_read_d  = in_range && ~op.write;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= MEM_STATE_IDLE;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_read_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_read_q  <= resp_read_d;
        end
    end

    memory_backing_store_byte_write_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (op.write),
        .be    (op.strobe),
        .addr  (op.address[ADDR_WIDTH-1:0]),
        .wdata (op.wdata),
        .rdata (ram_rdata)
    );

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_data  = resp_read_q ? ram_rdata : MEM_RESP_ERROR_DATA;

endmodule

// File: tb/tb_memory_backing_store.sv
// Scoreboard bench for memory_backing_store: latency, byte masks,
// back-to-back accepts, range errors and reset while a request is pending.
module tb_memory_backing_store;
    import memory_backing_store_pkg::*;

    localparam int AW  = 12;
    localparam int LAT = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   resp_cycs[$];
    logic [31:0] model [logic [31:0]];

    memory_backing_store_if bus();

    memory_backing_store #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .INIT_FILE  ("")
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (cyc > 0) begin
                if (bus.resp_valid) begin
                    check("resp_pulse_width", 64'(prev_valid), 64'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_data", 64'(bus.resp_data), 64'(e.data));
                        check("resp_error", 64'(bus.resp_error), 64'(e.err));
                        check("resp_latency", 64'(cyc - e.acc), 64'(LAT));
                        resp_cycs.push_back(cyc);
                    end
                end else begin
                    check("idle_data", 64'(bus.resp_data), 64'd0);
                    check("idle_error", 64'(bus.resp_error), 64'd0);
                end
            end
            prev_valid = bus.resp_valid;
        end
    end

    // Leaves req_valid high; caller drops it with req_idle when done.
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input bit expect_resp);
        exp_t e;
        bit done;
        logic [31:0] w;
        done = 0;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_wdata   = wd;
        bus.req_strobe  = strb;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                done  = 1;
                e.acc = cyc;
                e.err = (addr >> AW) != 0;
                e.data = 32'h0;
                if (expect_resp) begin
                    if (!e.err && wr) begin
                        w = model.exists(addr) ? model[addr] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (strb[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                        model[addr] = w;
                    end else if (!e.err) begin
                        e.data = model[addr];
                    end
                    sb.push_back(e);
                end
            end
            @(posedge clock);
            #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic req_idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic single(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb);
        do_req(wr, addr, wd, strb, 1'b1);
        req_idle();
        wait_drain();
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.req_strobe  = 4'h0;

        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_ready", 64'(bus.req_ready), 64'd0);
            check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);
        @(posedge clock);
        #1;

        single(1'b1, 32'd0, 32'hDEAD0000, MEM_STROBE_WORD);
        single(1'b1, 32'd1, 32'h000000A1, MEM_STROBE_WORD);
        single(1'b1, 32'd2, 32'h000000B2, MEM_STROBE_WORD);
        single(1'b1, 32'd3, 32'h000000C3, MEM_STROBE_WORD);
        single(1'b1, 32'd5, 32'h00500093, MEM_STROBE_WORD);
        single(1'b1, 32'd7, 32'h11223344, MEM_STROBE_WORD);
        single(1'b1, 32'd9, 32'h99990009, MEM_STROBE_WORD);

        single(1'b0, 32'd5, 32'h0, 4'h0);

        single(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101);
        single(1'b0, 32'd7, 32'h0, 4'h0);
        check("byte_mask_model", 64'(model[32'd7]), 64'h11BB33DD);

        single(1'b1, 32'd1, 32'hFFFFFFFF, 4'b0000);
        single(1'b0, 32'd1, 32'h0, 4'h0);

        resp_cycs.delete();
        do_req(1'b0, 32'd1, 32'h0, 4'h0, 1'b1);
        do_req(1'b0, 32'd2, 32'h0, 4'h0, 1'b1);
        do_req(1'b0, 32'd3, 32'h0, 4'h0, 1'b1);
        req_idle();
        wait_drain();
        check("b2b_count", 64'(resp_cycs.size()), 64'd3);
        for (int i = 1; i < resp_cycs.size(); i++)
            check("b2b_spacing", 64'(resp_cycs[i] - resp_cycs[i-1]),
                  64'(LAT));

        single(1'b1, 32'h00001000, 32'h12345678, MEM_STROBE_WORD);
        single(1'b0, 32'd0, 32'h0, 4'h0);
        single(1'b0, 32'h80000003, 32'h0, 4'h0);

        do_req(1'b1, 32'd9, 32'hFFFFFFFF, MEM_STROBE_WORD, 1'b0);
        req_idle();
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("midrst_ready", 64'(bus.req_ready), 64'd0);
            check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (LAT + 2) @(posedge clock);
        #1;
        single(1'b0, 32'd9, 32'h0, 4'h0);
        check("midrst_model", 64'(model[32'd9]), 64'h99990009);

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
